// File: rtl/fir_filter_mac_stage_if.sv
// ---------------------------------------------------------------------------
// fir_filter_mac_stage_if
// Tap/result bundle between the FIR get-data stage and the MAC stage.
//   master : drives the tap (data_in, coeff_in, valid_in, first_in, last_in)
//            and the pipeline controls (freeze_in, flush_in); receives results
//   slave  : the MAC stage; drives result_out, result_valid_out, overflow_out
// ---------------------------------------------------------------------------
interface fir_filter_mac_stage_if #(
  parameter int INPUT_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 32
);
  logic [INPUT_WIDTH-1:0]  data_in;
  logic [INPUT_WIDTH-1:0]  coeff_in;
  logic                    valid_in;
  logic                    first_in;
  logic                    last_in;
  logic                    freeze_in;
  logic                    flush_in;
  logic [OUTPUT_WIDTH-1:0] result_out;
  logic                    result_valid_out;
  logic                    overflow_out;

  modport master (
    output data_in, coeff_in, valid_in, first_in, last_in, freeze_in, flush_in,
    input  result_out, result_valid_out, overflow_out
  );

  modport slave (
    input  data_in, coeff_in, valid_in, first_in, last_in, freeze_in, flush_in,
    output result_out, result_valid_out, overflow_out
  );
endinterface

// File: rtl/fir_filter_mac_stage.sv
// ---------------------------------------------------------------------------
// fir_filter_mac_stage
// Three-stage signed multiply-accumulate for the FIR datapath.
//   P : registers data*coeff (2*INPUT_WIDTH bits) plus valid/first/last
//   A : overwrites (first) or saturating-adds the product into acc
//   R : acc >>> FRAC_BITS, clipped to OUTPUT_WIDTH, emitted on the batch's
//       last tap with a one-cycle result_valid_out / overflow_out pulse
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  fir_filter_mac_stage_if.slave (tap in, controls, result out)
// freeze_in holds every register; flush_in clears valids/flags/acc and wins
// over freeze_in. result_out holds its value between pulses.
// Optional: `define FIR_MAC_ROUND_EN adds round-half-up (saturating add of
// 2^(FRAC_BITS-1)) ahead of the output shift.
// ---------------------------------------------------------------------------
module fir_filter_mac_stage #(
  parameter int INPUT_WIDTH  = 32,
  parameter int GUARD_BITS   = 4,
  parameter int OUTPUT_WIDTH = 32,
  parameter int FRAC_BITS    = 31
) (
  input logic                  clk,
  input logic                  rst,
  fir_filter_mac_stage_if.slave bus
);
  localparam int PROD_W    = 2*INPUT_WIDTH;
  localparam int ACC_WIDTH = PROD_W + GUARD_BITS;
  localparam int EXT_W     = ((ACC_WIDTH > OUTPUT_WIDTH) ? ACC_WIDTH : OUTPUT_WIDTH) + 1;
  localparam int STAGES    = 1;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] OUT_MAX =
    {{(EXT_W-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN =
    {{(EXT_W-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic signed [PROD_W-1:0] prod;
    logic                     first;
    logic                     last;
  } p_stage_t;

  // vld_pipe[0] = P valid, vld_pipe[1] = A valid
  logic [STAGES:0]             vld_pipe;
  p_stage_t                    p_q;
  logic                        a_last;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        sat;
  logic [OUTPUT_WIDTH-1:0]     result_q;
  logic                        res_vld_q;
  logic                        ovf_q;

  // ---- P-stage product (operands sign-extended so the multiply is exact)
  logic signed [PROD_W-1:0] d_ext, c_ext, prod_d;
  always_comb begin
    d_ext  = {{INPUT_WIDTH{bus.data_in[INPUT_WIDTH-1]}},  bus.data_in};
    c_ext  = {{INPUT_WIDTH{bus.coeff_in[INPUT_WIDTH-1]}}, bus.coeff_in};
    prod_d = d_ext * c_ext;
  end

  // ---- A-stage saturating add
  logic signed [ACC_WIDTH-1:0] prod_ext, sum, acc_add;
  logic                        add_ovf;
  always_comb begin
    prod_ext = {{GUARD_BITS{p_q.prod[PROD_W-1]}}, p_q.prod};
    sum      = acc + prod_ext;
    // overflow only when both operands share a sign the sum does not
    add_ovf  = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    acc_add  = sum;
    if (add_ovf) acc_add = acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
  end

  // ---- R-stage scale and clip
  logic signed [ACC_WIDTH-1:0] acc_r, shifted;
  logic signed [EXT_W-1:0]     s_ext;
  logic                        rnd_ovf, clip;
  logic [OUTPUT_WIDTH-1:0]     clipped;
`ifdef FIR_MAC_ROUND_EN
  localparam logic signed [ACC_WIDTH-1:0] RND_HALF =
    {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
  logic signed [ACC_WIDTH-1:0] rnd_sum;
  always_comb begin
    rnd_sum = acc + RND_HALF;
    // adding a positive constant can only overflow upwards
    rnd_ovf = ~acc[ACC_WIDTH-1] & rnd_sum[ACC_WIDTH-1];
    acc_r   = rnd_ovf ? ACC_MAX : rnd_sum;
  end
`else
  always_comb begin
    rnd_ovf = 1'b0;
    acc_r   = acc;
  end
`endif

  always_comb begin
    shifted = acc_r >>> FRAC_BITS;
    s_ext   = {{(EXT_W-ACC_WIDTH){shifted[ACC_WIDTH-1]}}, shifted};
    clip    = 1'b0;
    clipped = s_ext[OUTPUT_WIDTH-1:0];
    if (s_ext > OUT_MAX) begin
      clip    = 1'b1;
      clipped = OUT_MAX[OUTPUT_WIDTH-1:0];
    end else if (s_ext < OUT_MIN) begin
      clip    = 1'b1;
      clipped = OUT_MIN[OUTPUT_WIDTH-1:0];
    end
  end

  // ---- pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      p_q       <= '0;
      a_last    <= 1'b0;
      acc       <= '0;
      sat       <= 1'b0;
      result_q  <= '0;
      res_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (bus.flush_in) begin
      vld_pipe  <= '0;
      p_q.first <= 1'b0;
      p_q.last  <= 1'b0;
      a_last    <= 1'b0;
      acc       <= '0;
      sat       <= 1'b0;
      res_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (!bus.freeze_in) begin
      // P
      vld_pipe  <= {vld_pipe[STAGES-1:0], bus.valid_in};
      p_q.prod  <= prod_d;
      p_q.first <= bus.valid_in & bus.first_in;
      p_q.last  <= bus.valid_in & bus.last_in;
      // A
      a_last    <= p_q.last;
      if (vld_pipe[0]) begin
        if (p_q.first) begin
          acc <= prod_ext;
          sat <= 1'b0;
        end else begin
          acc <= acc_add;
          if (add_ovf) sat <= 1'b1;
        end
      end
      // R
      if (vld_pipe[1] && a_last) begin
        result_q  <= clipped;
        res_vld_q <= 1'b1;
        ovf_q     <= sat | clip | rnd_ovf;
      end else begin
        res_vld_q <= 1'b0;
        ovf_q     <= 1'b0;
      end
    end
  end

  assign bus.result_out       = result_q;
  assign bus.result_valid_out = res_vld_q;
  assign bus.overflow_out     = ovf_q;
endmodule
